// File: rtl/tlb_pkg.sv
// Shared state encoding, default geometry and tree-PLRU helpers for the TLB.
package tlb_pkg;
    localparam int SADDR_DEF = 64;
    localparam int SPAGE_DEF = 12;
    localparam int NSET_DEF  = 8;
    localparam int NWAY_DEF  = 8;
    localparam int SPCID_DEF = 12;
    localparam int SSET_DEF  = $clog2(NSET_DEF);
    localparam int STAG_DEF  = SADDR_DEF - SPAGE_DEF - SSET_DEF;

    // Helpers operate on a 63-node tree, which covers up to 64 ways.
    localparam int PLRU_W  = 63;
    localparam int LVL_MAX = 6;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOOKUP    = 2'd1;
    localparam logic [1:0] ST_WAIT_FILL = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    function automatic logic [5:0] plru_victim(input logic [PLRU_W-1:0] bits, input int nway);
        logic [6:0] node;
        logic [6:0] leaf;
        node = '0;
        for (int l = 0; l < LVL_MAX; l++) begin
            if (l < $clog2(nway)) begin
                node = {node[5:0], 1'b0} + (bits[node[5:0]] ? 7'd2 : 7'd1);
            end
        end
        leaf = node - 7'(nway - 1);
        return leaf[5:0];
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [5:0] way, input int nway);
        logic [PLRU_W-1:0] res;
        logic [6:0]        node;
        logic [5:0]        shifted;
        int                lvls;
        res  = bits;
        node = '0;
        lvls = $clog2(nway);
        for (int l = 0; l < LVL_MAX; l++) begin
            if (l < lvls) begin
                // Way index MSB selects the root branch; each node points away from it.
                shifted = way >> (lvls - 1 - l);
                res[node[5:0]] = ~shifted[0];
                node = {node[5:0], 1'b0} + (shifted[0] ? 7'd2 : 7'd1);
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/tlb_way.sv
// One TLB way: NSET entries with a registered read port, a fill write port
// and a per-set valid clear used by the flush sweep.
module tlb_way
    import tlb_pkg::*;
#(
    parameter int NSET  = NSET_DEF,
    parameter int SSET  = $clog2(NSET),
    parameter int STAG  = STAG_DEF,
    parameter int SPCID = SPCID_DEF,
    parameter int SPPN  = SADDR_DEF - SPAGE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SSET-1:0]  rd_set,
    output logic             rd_valid,
    output logic [STAG-1:0]  rd_tag,
    output logic [SPCID-1:0] rd_pcid,
    output logic [SPPN-1:0]  rd_ppn,
    input  logic             wr_en,
    input  logic [SSET-1:0]  wr_set,
    input  logic [STAG-1:0]  wr_tag,
    input  logic [SPCID-1:0] wr_pcid,
    input  logic [SPPN-1:0]  wr_ppn,
    input  logic             clr_en,
    input  logic [SSET-1:0]  clr_set,
    input  logic             clr_all,
    input  logic [SPCID-1:0] clr_pcid
);
    logic [NSET-1:0]  valid_reg;
    logic [SPCID-1:0] pcid_reg [NSET];  // kept in flops: compared during a PCID sweep
    logic [STAG-1:0]  tag_mem  [NSET];
    logic [SPPN-1:0]  ppn_mem  [NSET];
    logic             clr_hit;

    assign clr_hit = clr_en && (clr_all || pcid_reg[clr_set] == clr_pcid);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_set] <= 1'b1;
        end else if (clr_hit) begin
            valid_reg[clr_set] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_set]  <= wr_tag;
            pcid_reg[wr_set] <= wr_pcid;
            ppn_mem[wr_set]  <= wr_ppn;
        end
        rd_tag  <= tag_mem[rd_set];
        rd_pcid <= pcid_reg[rd_set];
        rd_ppn  <= ppn_mem[rd_set];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= valid_reg[rd_set];
        end
    end
endmodule

// File: rtl/tlb_plru.sv
// Set-associative TLB with tree-PLRU replacement, walker fill handshake and
// a one-set-per-cycle flush sweep (all entries or PCID-selective).
module tlb_plru
    import tlb_pkg::*;
#(
    parameter int SADDR = SADDR_DEF,
    parameter int SPAGE = SPAGE_DEF,
    parameter int NSET  = NSET_DEF,
    parameter int NWAY  = NWAY_DEF,
    parameter int SPCID = SPCID_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SADDR-1:0] va,
    input  logic [SPCID-1:0] pcid,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [SADDR-1:0] resp_ta,
    output logic             miss,
    input  logic             fill_valid,
    input  logic [SADDR-1:0] fill_pa,
    input  logic             flush_all,
    input  logic             flush_pcid_valid,
    input  logic [SPCID-1:0] flush_pcid,
    output logic             flush_done
);
    localparam int SSET = $clog2(NSET);
    localparam int SWAY = $clog2(NWAY);
    localparam int STAG = SADDR - SPAGE - SSET;
    localparam int SPPN = SADDR - SPAGE;

    logic [1:0]       state_reg;
    logic [SADDR-1:0] va_reg;
    logic [SPCID-1:0] pcid_reg;
    logic [SSET-1:0]  cnt_reg;
    logic             flush_all_reg;
    logic [SPCID-1:0] flush_pcid_reg;
    logic [NWAY-2:0]  plru_reg [NSET];

    logic [SSET-1:0]  set_cur;
    logic [SSET-1:0]  rd_set;
    logic [STAG-1:0]  tag_cur;
    logic             wr_en;
    logic [NWAY-1:0]  rd_valid;
    logic [STAG-1:0]  rd_tag  [NWAY];
    logic [SPCID-1:0] rd_pcid [NWAY];
    logic [SPPN-1:0]  rd_ppn  [NWAY];
    logic [NWAY-1:0]  hit_vec;
    logic             hit_any;
    logic [SWAY-1:0]  hit_way;
    logic [SWAY-1:0]  free_way;
    logic [SWAY-1:0]  victim_way;
    logic [PLRU_W-1:0] plru_cur;
    logic [PLRU_W-1:0] plru_new;
    logic [5:0]       pv;
    logic             unused_bits;

    assign req_ready  = (state_reg == ST_IDLE) && !flush_all && !flush_pcid_valid;
    assign flush_done = (state_reg == ST_FLUSH) && (cnt_reg == SSET'(NSET - 1));
    assign set_cur    = va_reg[SPAGE +: SSET];
    assign tag_cur    = va_reg[SADDR-1:SPAGE+SSET];
    // In IDLE the read port tracks the incoming address so data is ready in LOOKUP.
    assign rd_set     = (state_reg == ST_IDLE) ? va[SPAGE +: SSET] : set_cur;
    assign wr_en      = (state_reg == ST_WAIT_FILL) && fill_valid;
    assign unused_bits = ^{fill_pa[SPAGE-1:0], pv, plru_new};

    for (genvar gi = 0; gi < NWAY; gi++) begin : g_way
        tlb_way #(
            .NSET (NSET),
            .SSET (SSET),
            .STAG (STAG),
            .SPCID(SPCID),
            .SPPN (SPPN)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .rd_set  (rd_set),
            .rd_valid(rd_valid[gi]),
            .rd_tag  (rd_tag[gi]),
            .rd_pcid (rd_pcid[gi]),
            .rd_ppn  (rd_ppn[gi]),
            .wr_en   (wr_en && victim_way == SWAY'(gi)),
            .wr_set  (set_cur),
            .wr_tag  (tag_cur),
            .wr_pcid (pcid_reg),
            .wr_ppn  (fill_pa[SADDR-1:SPAGE]),
            .clr_en  (state_reg == ST_FLUSH),
            .clr_set (cnt_reg),
            .clr_all (flush_all_reg),
            .clr_pcid(flush_pcid_reg)
        );
        assign hit_vec[gi] = rd_valid[gi] && rd_tag[gi] == tag_cur && rd_pcid[gi] == pcid_reg;
    end

    always_comb begin
        hit_any  = |hit_vec;
        hit_way  = '0;
        free_way = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = SWAY'(w);
            if (!rd_valid[w]) free_way = SWAY'(w);
        end
        plru_cur = '0;
        plru_cur[NWAY-2:0] = plru_reg[set_cur];
        pv = plru_victim(plru_cur, NWAY);
        victim_way = (&rd_valid) ? pv[SWAY-1:0] : free_way;
        plru_new = plru_touch(plru_cur, 6'((state_reg == ST_LOOKUP) ? hit_way : victim_way), NWAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            va_reg         <= '0;
            pcid_reg       <= '0;
            cnt_reg        <= '0;
            flush_all_reg  <= 1'b0;
            flush_pcid_reg <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_ta        <= '0;
            miss           <= 1'b0;
            for (int s = 0; s < NSET; s++) plru_reg[s] <= '0;
        end else begin
            resp_valid <= 1'b0;
            miss       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (flush_all || flush_pcid_valid) begin
                        state_reg      <= ST_FLUSH;
                        cnt_reg        <= '0;
                        flush_all_reg  <= flush_all;
                        flush_pcid_reg <= flush_pcid;
                    end else if (req_valid) begin
                        state_reg <= ST_LOOKUP;
                        va_reg    <= va;
                        pcid_reg  <= pcid;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_any) begin
                        resp_valid        <= 1'b1;
                        resp_hit          <= 1'b1;
                        resp_ta           <= {rd_ppn[hit_way], va_reg[SPAGE-1:0]};
                        plru_reg[set_cur] <= plru_new[NWAY-2:0];
                        state_reg         <= ST_IDLE;
                    end else begin
                        miss      <= 1'b1;
                        state_reg <= ST_WAIT_FILL;
                    end
                end
                ST_WAIT_FILL: begin
                    if (fill_valid) begin
                        resp_valid        <= 1'b1;
                        resp_hit          <= 1'b0;
                        resp_ta           <= {fill_pa[SADDR-1:SPAGE], va_reg[SPAGE-1:0]};
                        plru_reg[set_cur] <= plru_new[NWAY-2:0];
                        state_reg         <= ST_IDLE;
                    end
                end
                default: begin
                    if (flush_all_reg) plru_reg[cnt_reg] <= '0;
                    if (cnt_reg == SSET'(NSET - 1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_plru.sv
// Randomized and directed bench for tlb_plru against a timestamp-based PLRU reference model.
module tb_tlb_plru;
    localparam int NSET = 8;
    localparam int NWAY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] va;
    logic [11:0] pcid;
    logic        resp_valid;
    logic        resp_hit;
    logic [63:0] resp_ta;
    logic        miss;
    logic        fill_valid;
    logic [63:0] fill_pa;
    logic        flush_all;
    logic        flush_pcid_valid;
    logic [11:0] flush_pcid;
    logic        flush_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain per-entry arrays plus last-touch timestamps.
    bit          m_valid [NSET][NWAY];
    logic [48:0] m_tag   [NSET][NWAY];
    logic [11:0] m_pcid  [NSET][NWAY];
    logic [51:0] m_ppn   [NSET][NWAY];
    longint      m_last  [NSET][NWAY];
    longint      m_time = 0;

    tlb_plru dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .va              (va),
        .pcid            (pcid),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_ta         (resp_ta),
        .miss            (miss),
        .fill_valid      (fill_valid),
        .fill_pa         (fill_pa),
        .flush_all       (flush_all),
        .flush_pcid_valid(flush_pcid_valid),
        .flush_pcid      (flush_pcid),
        .flush_done      (flush_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NWAY; w++) begin
                m_valid[s][w] = 1'b0;
                m_last[s][w]  = 0;
            end
    endtask

    function automatic int m_find(int s, logic [48:0] t, logic [11:0] p);
        for (int w = 0; w < NWAY; w++)
            if (m_valid[s][w] && m_tag[s][w] == t && m_pcid[s][w] == p) return w;
        return -1;
    endfunction

    // Tree PLRU seen as ranges: each split points away from the most recently used way inside it.
    function automatic int m_victim(int s);
        int lo, size, half, best;
        longint bt;
        for (int w = 0; w < NWAY; w++)
            if (!m_valid[s][w]) return w;
        lo = 0;
        size = NWAY;
        while (size > 1) begin
            half = size / 2;
            best = -1;
            bt = 0;
            for (int w = lo; w < lo + size; w++)
                if (m_last[s][w] > bt) begin
                    bt = m_last[s][w];
                    best = w;
                end
            if (best >= 0 && best < lo + half) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic m_touch(int s, int w);
        m_time++;
        m_last[s][w] = m_time;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic do_lookup(input logic [63:0] a, input logic [11:0] p, input logic [63:0] fpa,
                             output logic hit_o, output logic [63:0] ta_o);
        int s, w, wait_n;
        logic [48:0] t;
        s = int'(a[14:12]);
        t = a[63:15];
        wait_ready();
        va = a;
        pcid = p;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("lookup_quiet", {62'd0, resp_valid, miss}, 64'd0);
        @(negedge clk);
        w = m_find(s, t, p);
        if (w >= 0) begin
            check("hit_valid", 64'(resp_valid), 64'd1);
            check("hit_flag", 64'(resp_hit), 64'd1);
            check("hit_ta", resp_ta, {m_ppn[s][w], a[11:0]});
            check("hit_nomiss", 64'(miss), 64'd0);
            m_touch(s, w);
            hit_o = resp_hit & resp_valid;
        end else begin
            check("miss_pulse", 64'(miss), 64'd1);
            check("miss_noresp", 64'(resp_valid), 64'd0);
            wait_n = int'($urandom_range(0, 3));
            repeat (wait_n) begin
                @(negedge clk);
                check("fill_wait", {62'd0, resp_valid, miss}, 64'd0);
            end
            fill_valid = 1'b1;
            fill_pa = fpa;
            @(negedge clk);
            fill_valid = 1'b0;
            check("fill_valid", 64'(resp_valid), 64'd1);
            check("fill_hit", 64'(resp_hit), 64'd0);
            check("fill_ta", resp_ta, {fpa[63:12], a[11:0]});
            hit_o = resp_hit & resp_valid;
            w = m_victim(s);
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            m_pcid[s][w]  = p;
            m_ppn[s][w]   = fpa[63:12];
            m_touch(s, w);
        end
        ta_o = resp_ta;
        $display("[TB] lookup va=%h pcid=%0d hit=%0d ta=%h", a, p, hit_o, ta_o);
    endtask

    task automatic do_flush(input bit all, input logic [11:0] p);
        int n;
        bit done;
        wait_ready();
        if (all) flush_all = 1'b1;
        else begin
            flush_pcid_valid = 1'b1;
            flush_pcid = p;
        end
        #1;
        check("flush_ready_low", 64'(req_ready), 64'd0);
        n = 0;
        done = 1'b0;
        while (!done && n < 4 * NSET) begin
            @(negedge clk);
            n++;
            if (flush_done) done = 1'b1;
        end
        check("flush_len", 64'(n), 64'(NSET));
        flush_all = 1'b0;
        flush_pcid_valid = 1'b0;
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NWAY; w++) begin
                if (all || m_pcid[s][w] == p) m_valid[s][w] = 1'b0;
                if (all) m_last[s][w] = 0;
            end
        @(negedge clk);
        check("flush_done_pulse", 64'(flush_done), 64'd0);
        $display("[TB] flush all=%0d pcid=%0d cycles=%0d", all, p, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_hit"}, 64'(resp_hit), 64'd0);
        check({tag, "_miss"}, 64'(miss), 64'd0);
        check({tag, "_resp_ta"}, resp_ta, 64'd0);
        check({tag, "_flush_done"}, 64'(flush_done), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic        h;
        logic [63:0] t;
        logic [63:0] a;
        int          n, seen;
        rst = 1'b1;
        req_valid = 1'b0;
        va = '0;
        pcid = '0;
        fill_valid = 1'b0;
        fill_pa = '0;
        flush_all = 1'b0;
        flush_pcid_valid = 1'b0;
        flush_pcid = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Cold miss, warm hit, PCID isolation.
        do_lookup(64'h5123, 12'd3, 64'hABC000, h, t);
        check("cold_hit", 64'(h), 64'd0);
        check("cold_ta", t, 64'hABC123);
        do_lookup(64'h5123, 12'd3, 64'h0, h, t);
        check("warm_hit", 64'(h), 64'd1);
        check("warm_ta", t, 64'hABC123);
        do_lookup(64'h5123, 12'd4, 64'hDEF000, h, t);
        check("pcid_iso", 64'(h), 64'd0);

        // PLRU: fill set 0 in way order, touch way 0, ninth tag evicts way 4.
        for (int i = 0; i < 8; i++)
            do_lookup((64'(i + 1) << 15) | 64'h10, 12'd1, {32'($urandom), 32'($urandom)}, h, t);
        do_lookup(64'(1) << 15, 12'd1, 64'h0, h, t);
        check("plru_touch0", 64'(h), 64'd1);
        do_lookup(64'(9) << 15, 12'd1, 64'h123000, h, t);
        check("plru_ninth", 64'(h), 64'd0);
        do_lookup(64'(1) << 15, 12'd1, 64'h0, h, t);
        check("plru_way0_kept", 64'(h), 64'd1);
        do_lookup(64'(5) << 15, 12'd1, 64'h456000, h, t);
        check("plru_way4_gone", 64'(h), 64'd0);

        // PCID-selective flush in set 2.
        a = (64'd20 << 15) | (64'd2 << 12) | 64'h44;
        do_lookup(a, 12'd3, 64'h333000, h, t);
        do_lookup(a, 12'd5, 64'h555000, h, t);
        do_flush(1'b0, 12'd3);
        do_lookup(a, 12'd3, 64'h777000, h, t);
        check("pflush_p3_miss", 64'(h), 64'd0);
        do_lookup(a, 12'd5, 64'h0, h, t);
        check("pflush_p5_hit", 64'(h), 64'd1);
        check("pflush_p5_ta", t, 64'h555044);

        // Flush-all takes priority over a simultaneous request.
        flush_all = 1'b1;
        req_valid = 1'b1;
        va = 64'h5123;
        pcid = 12'd3;
        #1;
        check("fa_ready_low", 64'(req_ready), 64'd0);
        n = 0;
        seen = 0;
        while (!flush_done && n < 4 * NSET) begin
            @(negedge clk);
            n++;
            if (req_ready || resp_valid || miss) seen++;
        end
        check("fa_len", 64'(n), 64'(NSET));
        check("fa_req_held", 64'(seen), 64'd0);
        flush_all = 1'b0;
        req_valid = 1'b0;
        m_reset();
        $display("[TB] flush_all with pending request cycles=%0d", n);
        @(negedge clk);
        do_lookup(64'h5123, 12'd3, 64'hABC000, h, t);
        check("fa_after_miss", 64'(h), 64'd0);

        // Reset while waiting for the walker.
        wait_ready();
        va = (64'd7 << 15) | (64'd3 << 12);
        pcid = 12'd2;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rm_miss", 64'(miss), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_reset_outputs("rm");
        fill_valid = 1'b1;
        fill_pa = 64'h999000;
        @(negedge clk);
        fill_valid = 1'b0;
        check("rm_fill_ignored", 64'(resp_valid), 64'd0);
        $display("[TB] reset during fill wait");
        do_lookup(64'h5123, 12'd3, 64'hABC000, h, t);
        check("rm_after_miss", 64'(h), 64'd0);

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_flush(1'b1, 12'd0);
            end else if (r == 1) begin
                do_flush(1'b0, 12'($urandom_range(0, 3)));
            end else begin
                a = (64'($urandom_range(0, 15)) << 15) | (64'($urandom_range(0, 7)) << 12)
                    | 64'($urandom_range(0, 4095));
                do_lookup(a, 12'($urandom_range(0, 3)), {32'($urandom), 32'($urandom)}, h, t);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
